sort_drain: RTL and testbench

Buffered sort-and-unload stage for the sequence sorter. It collects up to N unsigned samples from an upstream valid/ready stream and keeps them in descending order as they arrive, one insertion per cycle. It then drains the set downstream, largest first, with a last-beat marker. It sits after the comparator chain and provides the read-out side that the chain itself lacks.

---
 rtl/sorter_pkg.sv | 10 +
 rtl/sort_insert_slot.sv | 36 +++
 rtl/sort_drain.sv | 96 +++++++++
 tb/tb_sort_drain.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared definitions for the sequence sorter read-out stage.
package sorter_pkg;
  localparam int DW_DEF = 8;
  localparam int N_DEF  = 4;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } sd_state_t;
endpackage

// File: rtl/sort_insert_slot.sv
// One cell of the descending sort buffer: hold, take new sample,
// take upper neighbour (insert shift) or take lower neighbour (drain shift).
module sort_insert_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ins_en,
  input  logic          shf_en,
  input  logic          occ,
  input  logic          up_keep,
  input  logic [DW-1:0] new_data,
  input  logic [DW-1:0] up_data,
  input  logic [DW-1:0] dn_data,
  output logic          keep,
  output logic [DW-1:0] q
);
  logic [DW-1:0] q_q, q_d;

  // >= keeps an equal held value above the newcomer, so ties stay in arrival order
  assign keep = occ && (q_q >= new_data);
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (shf_en)
      q_d = dn_data;
    else if (ins_en && !keep)
      q_d = up_keep ? new_data : up_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end
endmodule

// File: rtl/sort_drain.sv
// Collects up to N samples in descending order, then drains them largest
// first with a last-beat marker.
module sort_drain
  import sorter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  output logic          out_ready_unused_n,
  input  logic          out_ready,
  output logic          busy
);
  localparam int CW = $clog2(N + 1);

  sd_state_t           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N-1:0][DW-1:0] slot;
  logic [N-1:0]        keep;
  logic                accept, pop;

  assign accept = (state_q == LOAD) && in_valid;
  assign pop    = (state_q == DRAIN) && out_ready;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_slot
      logic          up_keep;
      logic [DW-1:0] up_data, dn_data;
      // slot 0 has no upper neighbour: any non-kept value there is replaced by the newcomer
      if (i == 0) begin : g_top
        assign up_keep = 1'b1;
        assign up_data = '0;
      end else begin : g_mid
        assign up_keep = keep[i-1];
        assign up_data = slot[i-1];
      end
      if (i == N - 1) begin : g_bot
        assign dn_data = '0;
      end else begin : g_nbot
        assign dn_data = slot[i+1];
      end

      sort_insert_slot #(.DW(DW)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins_en   (accept),
        .shf_en   (pop),
        .occ      (cnt_q > CW'(i)),
        .up_keep  (up_keep),
        .new_data (in_data),
        .up_data  (up_data),
        .dn_data  (dn_data),
        .keep     (keep[i]),
        .q        (slot[i])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + CW'(1);
      if (in_last || cnt_q == CW'(N - 1)) state_d = DRAIN;
    end else if (pop) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready           = (state_q == LOAD);
  assign out_valid          = (state_q == DRAIN);
  assign busy               = (state_q == DRAIN);
  assign out_last           = (state_q == DRAIN) && (cnt_q == CW'(1));
  assign out_data           = slot[0];
  assign out_ready_unused_n = 1'b0;
endmodule

// File: tb/tb_sort_drain.sv
// Directed scoreboard bench for sort_drain (DW=8, N=4).
module tb_sort_drain;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready, busy, spare;

  logic [8:0] exp_q[$];
  logic [7:0] cur[$];
  int         total = 0, passes = 0;

  always #5 clk = ~clk;

  sort_drain #(.DW(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready_unused_n(spare), .out_ready(out_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // stable descending order: repeatedly take the first occurrence of the maximum
  task automatic close_seq();
    while (cur.size() > 0) begin
      int mi = 0;
      for (int j = 1; j < cur.size(); j++) if (cur[j] > cur[mi]) mi = j;
      exp_q.push_back({cur.size() == 1, cur[mi]});
      cur.delete(mi);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    chk("in_ready_load", in_ready, 1);
    in_valid = 1'b1; in_data = d; in_last = last;
    cur.push_back(d);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (last || cur.size() == 4) close_seq();
  endtask

  task automatic drain(input int n, input bit bp);
    int got = 0, cyc = 0;
    logic [7:0] held = '0;
    bit stalled = 0;
    logic [8:0] e;
    while (got < n && cyc < 60) begin
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      chk("out_valid_drain", out_valid, 1);
      chk("in_ready_drain", in_ready, 0);
      chk("busy_drain", busy, 1);
      if (stalled) chk("out_data_stall", out_data, held);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[7:0]);
          chk("out_last", out_last, e[8]);
        end
        got++; stalled = 0;
      end else begin
        held = out_data; stalled = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_beats", got, n);
  endtask

  task automatic idle_checks();
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // full fill, closed by in_last on the fourth beat
    push(8'd3, 0); push(8'd9, 0); push(8'd1, 0); push(8'd7, 1);
    drain(4, 0);
    idle_checks();

    // early close
    push(8'd5, 0); push(8'd2, 1);
    drain(2, 0);
    idle_checks();

    // ties and extremes, closed by depth
    push(8'd255, 0); push(8'd0, 0); push(8'd255, 0); push(8'd0, 0);
    drain(4, 0);
    idle_checks();

    // backpressure
    push(8'd11, 0); push(8'd44, 0); push(8'd22, 0); push(8'd33, 0);
    drain(4, 1);
    idle_checks();

    // single sample; in_valid held during drain must be ignored
    push(8'd42, 1);
    in_valid = 1'b1; in_data = 8'd99;
    for (int k = 0; k < 2; k++) begin
      chk("single_hold_data", out_data, 8'd42);
      chk("single_hold_last", out_last, 1);
      chk("single_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain(1, 0);
    idle_checks();

    // async reset mid-drain
    push(8'd10, 0); push(8'd20, 0); push(8'd30, 0); push(8'd40, 0);
    drain(1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data, 0);
    exp_q.delete(); cur.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push(8'd4, 0); push(8'd8, 1);
    drain(2, 0);
    idle_checks();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
